// File: rtl/imem_loader.sv
// imem_loader: receives a big-endian, length-prefixed program image over a
// valid/ready byte stream and writes it into instruction memory one 32-bit word
// at a time. The CPU is held in reset for the whole load. Stalls in any
// byte-waiting state are bounded by an idle timeout.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing
// checksum byte (XOR of all word bytes) before the load is reported as done.
// The 16-bit length field limits useful ADDR_W to 16 or less.
module imem_loader #(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam int                TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]     IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]     IDLE_ONE  = TW'(1);
    localparam logic [31:0]       MAX_N     = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0]   IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q;
    logic [7:0]          len_hi_q;
    logic [ADDR_W:0]     n_q;         // word count of the current load
    logic [ADDR_W:0]     idx_q;       // one bit wider than the address: N=2^ADDR_W never wraps
    logic [1:0]          byte_cnt_q;  // bytes already collected for the current word
    logic [23:0]         asm_q;       // first three bytes of the word being assembled
    logic [TW-1:0]       idle_q;      // clocks since last accepted byte or state entry
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q;       // running XOR of all word bytes
`endif

    logic                byte_ready_q;
    logic                wren_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [31:0]         wdata_q;
    logic                hold_q;
    logic                done_q;
    logic                error_q;

    logic                accept;
    logic [31:0]         len_w;
    logic                len_bad;
    logic [ADDR_W:0]     idx_d;
    logic [31:0]         word_d;
    logic                timeout;

    assign accept  = byte_valid & byte_ready_q;
    assign len_w   = {16'd0, len_hi_q, byte_data};
    assign len_bad = (len_w == 32'd0) || (len_w > MAX_N);
    assign idx_d   = idx_q + IDX_ONE;
    assign word_d  = {asm_q, byte_data};
    assign timeout = (idle_q == IDLE_LAST);

    // Load sequencer: state, counters and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            idle_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= '0;
`endif
            byte_ready_q <= 1'b0;
            wren_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                // Only IDLE and ERROR honour load_start; cpu_hold is raised on the same edge.
                S_IDLE, S_ERROR: begin
                    if (load_start) begin
                        state_q      <= S_LEN_HI;
                        byte_ready_q <= 1'b1;
                        hold_q       <= 1'b1;
                        error_q      <= 1'b0;
                        idx_q        <= '0;
                        byte_cnt_q   <= '0;
                        idle_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q        <= '0;
`endif
                    end
                end

                S_LEN_HI: begin
                    if (accept) begin
                        len_hi_q <= byte_data;
                        state_q  <= S_LEN_LO;
                        idle_q   <= '0;
                    end else if (timeout) begin
                        state_q      <= S_ERROR;
                        byte_ready_q <= 1'b0;
                        error_q      <= 1'b1;
                    end else begin
                        idle_q <= idle_q + IDLE_ONE;
                    end
                end

                S_LEN_LO: begin
                    if (accept) begin
                        idle_q <= '0;
                        if (len_bad) begin
                            state_q      <= S_ERROR;
                            byte_ready_q <= 1'b0;
                            error_q      <= 1'b1;
                        end else begin
                            n_q        <= len_w[ADDR_W:0];
                            byte_cnt_q <= '0;
                            state_q    <= S_DATA;
                        end
                    end else if (timeout) begin
                        state_q      <= S_ERROR;
                        byte_ready_q <= 1'b0;
                        error_q      <= 1'b1;
                    end else begin
                        idle_q <= idle_q + IDLE_ONE;
                    end
                end

                // The fourth byte completes the word and presents it for exactly one WRITE cycle.
                S_DATA: begin
                    if (accept) begin
                        asm_q      <= word_d[23:0];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        idle_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q      <= xor_q ^ byte_data;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            state_q      <= S_WRITE;
                            byte_ready_q <= 1'b0;
                            wren_q       <= 1'b1;
                            waddr_q      <= idx_q[ADDR_W-1:0];
                            wdata_q      <= word_d;
                        end
                    end else if (timeout) begin
                        state_q      <= S_ERROR;
                        byte_ready_q <= 1'b0;
                        error_q      <= 1'b1;
                    end else begin
                        idle_q <= idle_q + IDLE_ONE;
                    end
                end

                S_WRITE: begin
                    wren_q <= 1'b0;
                    idx_q  <= idx_d;
                    idle_q <= '0;
                    if (idx_d == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q      <= S_CHECK;
                        byte_ready_q <= 1'b1;
`else
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
`endif
                    end else begin
                        state_q      <= S_DATA;
                        byte_ready_q <= 1'b1;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        byte_ready_q <= 1'b0;
                        idle_q       <= '0;
                        if (byte_data == xor_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end else if (timeout) begin
                        state_q      <= S_ERROR;
                        byte_ready_q <= 1'b0;
                        error_q      <= 1'b1;
                    end else begin
                        idle_q <= idle_q + IDLE_ONE;
                    end
                end
`endif

                // CPU is released on the edge that leaves DONE.
                S_DONE: begin
                    done_q  <= 1'b0;
                    hold_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q      <= S_IDLE;
                    byte_ready_q <= 1'b0;
                    wren_q       <= 1'b0;
                    done_q       <= 1'b0;
                    hold_q       <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_wren  = wren_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven loads, directed multi-cycle
// sequences (reset mid-load, length errors, full-size load, timeout,
// checksum) and randomized loads checked against a stream-level model.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int AW = 12;
    localparam int TO = 20;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          load_start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_wren;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;

    imem_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_wren  (imem_wren),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        int          nw;
        logic        corrupt;
        logic        exp_err;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          viol = 0;
    int          done_base, wq_base, viol_base;
    wr_t         wq[$];
    logic [31:0] words[$];
    logic [7:0]  stream[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observe the write port and done pulses mid-cycle.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (load_done === 1'b1) done_cnt++;
            if (imem_wren === 1'b1) begin
                wq.push_back({imem_waddr, imem_wdata});
                if (byte_ready !== 1'b0) viol++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int k, input bit ls);
        for (int i = 0; i < k; i++) begin
            load_start = ls && (i == 0);
            @(posedge clock); #1;
        end
        load_start = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clock); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 40) chk("ready_wait", 64'(n), 64'd0);
        else begin
            @(posedge clock); #1;
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Serialise length + words MSB first, plus the XOR checksum when configured.
    task automatic build(input logic [15:0] len, input logic corrupt);
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        stream.delete();
        stream.push_back(len[15:8]);
        stream.push_back(len[7:0]);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int j = 3; j >= 0; j--) begin
                stream.push_back(w[8*j +: 8]);
                x = x ^ w[8*j +: 8];
            end
        end
        if (CS_EN && words.size() > 0) stream.push_back(corrupt ? (x ^ 8'h5A) : x);
    endtask

    task automatic play(input int maxgap, input bit inj);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i]);
            if (i < stream.size() - 1)
                idle(int'($urandom_range(maxgap, 0)), inj && (i >= 2) && ($urandom % 3 == 0));
        end
    endtask

    task automatic mark();
        done_base = done_cnt;
        wq_base   = wq.size();
        viol_base = viol;
    endtask

    task automatic finish_check(input logic exp_err);
        int bad;
        idle(4, 1'b0);
        chk("load_error", 64'(load_error), 64'(exp_err));
        chk("cpu_hold_end", 64'(cpu_hold), 64'(exp_err));
        chk("byte_ready_end", 64'(byte_ready), 64'd0);
        chk("done_pulses", 64'(done_cnt - done_base), exp_err ? 64'd0 : 64'd1);
        chk("write_count", 64'(wq.size() - wq_base), 64'(words.size()));
        bad = 0;
        for (int i = 0; i < words.size() && wq_base + i < wq.size(); i++)
            if (wq[wq_base + i].a != AW'(i) || wq[wq_base + i].d != words[i]) bad++;
        chk("write_data", 64'(bad), 64'd0);
        chk("ready_in_write", 64'(viol - viol_base), 64'd0);
    endtask

    task automatic do_load(input logic [15:0] len, input logic corrupt, input int maxgap,
                           input bit inj, input logic exp_err);
        build(len, corrupt);
        mark();
        pulse_start();
        play(maxgap, inj);
        finish_check(exp_err);
    endtask

    initial begin
        vec_t          vt[7];
        logic [15:0]   len;
        logic          corrupt, len_bad, exp_err;
        logic [AW-1:0] la;
        int            k, rdy_hi;

        reset = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

        // ---- reset state ----
        #3 reset = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst_byte_ready", 64'(byte_ready), 64'd0);
        chk("rst_wren", 64'(imem_wren), 64'd0);
        chk("rst_waddr", 64'(imem_waddr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_cpu_hold", 64'(cpu_hold), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_error", 64'(load_error), 64'd0);
        reset = 1'b1;
        idle(2, 1'b0);
        // IDLE ignores bytes
        byte_valid = 1'b1; byte_data = 8'hA5;
        idle(3, 1'b0);
        chk("idle_ready", 64'(byte_ready), 64'd0);
        byte_valid = 1'b0;

        // ---- table-driven loads ----
        vt[0] = '{16'd1,     1,   1'b0, 1'b0};
        vt[1] = '{16'd3,     3,   1'b0, 1'b0};
        vt[2] = '{16'd0,     0,   1'b0, 1'b1};
        vt[3] = '{16'd4097,  0,   1'b0, 1'b1};
        vt[4] = '{16'hFFFF,  0,   1'b0, 1'b1};
        vt[5] = '{16'd2,     2,   1'b1, CS_EN};
        vt[6] = '{16'h0100,  256, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            fill_words(vt[i].nw);
            do_load(vt[i].len, vt[i].corrupt, 1, 1'b0, vt[i].exp_err);
        end

        // ---- example load with cpu_hold timing ----
        words.delete();
        words.push_back(32'h20000005);
        words.push_back(32'h00000000);
        build(16'd2, 1'b0);
        mark();
        pulse_start();
        chk("ex_hold_start", 64'(cpu_hold), 64'd1);
        chk("ex_ready_start", 64'(byte_ready), 64'd1);
        chk("ex_err_clear", 64'(load_error), 64'd0);
        play(0, 1'b0);
        k = 0;
        while (load_done !== 1'b1 && k < 8) begin
            chk("ex_hold_before_done", 64'(cpu_hold), 64'd1);
            @(posedge clock); #1;
            k++;
        end
        chk("ex_done_seen", 64'(load_done), 64'd1);
        chk("ex_hold_in_done", 64'(cpu_hold), 64'd1);
        @(posedge clock); #1;
        chk("ex_hold_after_done", 64'(cpu_hold), 64'd0);
        chk("ex_done_one_cycle", 64'(load_done), 64'd0);
        finish_check(1'b0);

        // ---- length errors and recovery ----
        words.delete();
        do_load(16'h0000, 1'b0, 0, 1'b0, 1'b1);
        do_load(16'h1001, 1'b0, 0, 1'b0, 1'b1);
        fill_words(1);
        build(16'd1, 1'b0);
        mark();
        pulse_start();
        chk("recover_err_clear", 64'(load_error), 64'd0);
        chk("recover_ready", 64'(byte_ready), 64'd1);
        chk("recover_hold", 64'(cpu_hold), 64'd1);
        play(0, 1'b0);
        finish_check(1'b0);

        // ---- reset in the middle of DATA ----
        fill_words(2);
        build(16'd2, 1'b0);
        mark();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stream[i]);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(byte_ready), 64'd0);
        chk("mid_rst_wren", 64'(imem_wren), 64'd0);
        chk("mid_rst_waddr", 64'(imem_waddr), 64'd0);
        chk("mid_rst_wdata", 64'(imem_wdata), 64'd0);
        chk("mid_rst_hold", 64'(cpu_hold), 64'd0);
        chk("mid_rst_done", 64'(load_done), 64'd0);
        chk("mid_rst_error", 64'(load_error), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        rdy_hi = 0;
        for (int i = 0; i < 6; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            @(posedge clock); #1;
            if (byte_ready !== 1'b0) rdy_hi++;
        end
        byte_valid = 1'b0;
        chk("post_rst_ready", 64'(rdy_hi), 64'd0);
        chk("post_rst_writes", 64'(wq.size() - wq_base), 64'd0);
        chk("post_rst_hold", 64'(cpu_hold), 64'd0);

        // ---- timeout: TO idle clocks fail, TO-1 do not ----
        fill_words(1);
        build(16'd1, 1'b0);
        mark();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(stream[i]);
        idle(TO - 1, 1'b0);
        chk("to_before_expiry", 64'(load_error), 64'd0);
        idle(1, 1'b0);
        chk("to_at_expiry", 64'(load_error), 64'd1);
        chk("to_hold", 64'(cpu_hold), 64'd1);
        chk("to_ready", 64'(byte_ready), 64'd0);
        chk("to_writes", 64'(wq.size() - wq_base), 64'd0);
        mark();
        pulse_start();
        chk("to_restart_clear", 64'(load_error), 64'd0);
        for (int i = 0; i < 4; i++) send_byte(stream[i]);
        idle(TO - 1, 1'b0);
        chk("to_one_short", 64'(load_error), 64'd0);
        for (int i = 4; i < stream.size(); i++) send_byte(stream[i]);
        finish_check(1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---- checksum mismatch then match (expected 0x08) ----
        words.delete();
        words.push_back(32'h12345678);
        stream.delete();
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        mark();
        pulse_start();
        play(0, 1'b0);
        finish_check(1'b1);
        stream[6] = 8'h08;
        mark();
        pulse_start();
        play(0, 1'b0);
        finish_check(1'b0);
`endif

        // ---- full-size load, byte_valid every other cycle ----
        fill_words(4096);
        build(16'd4096, 1'b0);
        mark();
        pulse_start();
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i]);
            idle(1, 1'b0);
        end
        finish_check(1'b0);
        la = (wq.size() > wq_base) ? wq[wq.size() - 1].a : '0;
        chk("full_last_addr", 64'(la), 64'hFFF);

        // ---- randomized loads against the stream model ----
        for (int it = 0; it < 25; it++) begin
            k = int'($urandom % 10);
            if (k == 0)      len = 16'd0;
            else if (k == 1) len = 16'(4097 + ($urandom % 61438));
            else             len = 16'($urandom_range(6, 1));
            corrupt = ($urandom % 4 == 0);
            len_bad = (len == 16'd0) || (len > 16'd4096);
            exp_err = len_bad || (CS_EN && corrupt);
            if (len_bad) words.delete();
            else fill_words(int'(len));
            do_load(len, corrupt, 3, 1'b1, exp_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
